data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the EX/MEM pipeline register and the word-wide main data memory. Serves loads and stores from the MEM stage in a single cycle on a hit. On a miss it stalls the pipeline, writes back a dirty victim line, refills the line, then completes the access.

## Interface
Parameters:
- LINES, 32: number of cache lines; power of two.
- WORDS, 4: 32-bit words per line; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  CPU access valid (MemRead | MemWrite from EX/MEM).
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address; bits [1:0] ignored.
- wdata_i  in  32  store data.
- rdata_o  out  32  load data; valid when req_i & ~we_i & ~stall_o.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB while high.
- mem_req_o  out  1  memory beat request.
- mem_we_o  out  1  1 = writeback beat, 0 = refill beat.
- mem_addr_o  out  32  word-aligned beat address.
- mem_wdata_o  out  32  writeback data.
- mem_rdata_i  in  32  refill data; valid with mem_ack_i.
- mem_ack_i  in  1  beat complete; sampled only while mem_req_o high.

## Operation
- Address split (defaults): word = [3:2], index = [8:4], tag = [31:9]. In general: word = log2(WORDS) bits above [1:0], index = log2(LINES) bits above word, tag = remainder.
- Per line storage: valid bit, dirty bit, tag, WORDS data words.
- hit = req_i & valid[index] & (tag[index] == addr tag).
- FSM states:
  - IDLE: hit load → rdata_o = line word, combinational. Hit store → write word and set dirty at the edge. Miss → WRITEBACK if the victim is valid & dirty, else REFILL.
  - WRITEBACK: WORDS beats, word 0 first. mem_addr_o = {victim tag, index, beat, 2'b00}. After the last ack → REFILL.
  - REFILL: WORDS beats, word 0 first. mem_addr_o = {addr tag, index, beat, 2'b00}. Each ack writes mem_rdata_i into word[beat]. After the last ack, set valid and tag and clear dirty → IDLE.
- Back in IDLE the access is re-evaluated and hits. A store hit then sets dirty.
- Beat counter is log2(WORDS) bits, cleared on entry to WRITEBACK/REFILL and incremented per ack. The last beat is counter == WORDS-1; no wrap past it.
- stall_o = (state != IDLE) | (req_i & ~hit), combinational.
- mem_req_o stays high continuously across all beats of a burst. It drops in the cycle after the last ack.
- The CPU holds req_i/we_i/addr_i/wdata_i stable while stall_o is high. Behaviour is undefined otherwise.
- Reset clears all valid and dirty bits, sets state = IDLE and beat counter = 0. Reset mid-burst abandons the transfer and discards dirty data; mem_req_o is 0 the cycle after.
- A mem_ack_i arriving while mem_req_o is low is ignored.

## Timing
- Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, state IDLE. stall_o=0 and rdata_o=0 when req_i=0.
- Hit: 0 stall cycles; load data is available in the same cycle.
- Clean miss: stall = (cycles to complete WORDS acks) + 1. With zero-wait memory (ack every cycle) and WORDS=4, that is 5 stall cycles.
- Dirty miss: stall = 2·WORDS acks + 1; 9 cycles with zero-wait memory.
- mem_addr_o/mem_wdata_o change only at an acked edge or on state entry.

## Structure
- Package data_cache_pkg holds:
  - the state enum (IDLE, WRITEBACK, REFILL);
  - localparam helpers for the WORD_W, INDEX_W and TAG_W field widths derived from LINES/WORDS.
- Sub-module data_cache_array: tag, valid, dirty and data storage.
  - Combinational read port indexed by index/word.
  - One synchronous word write port.
  - Per-line valid/dirty/tag update.
  - Bulk valid/dirty clear on rst_i.
- data_cache holds the FSM, beat counter, hit logic and memory port.

## Test plan
- Cold load: reset, then load 0x0000_0100 with memory returning 0x11,0x22,0x33,0x44 on zero-wait acks.
  - Response: 4 refill beats at 0x100..0x10C, stall 5 cycles, rdata_o=0x11.
  - A following load of 0x104 hits with 0 stall and rdata_o=0x22.
- Store hit: store 0xDEAD_BEEF to 0x108 after the refill.
  - Response: no stall, no memory traffic. A later load of 0x108 returns 0xDEAD_BEEF.
- Dirty eviction: with 0x100 line dirty, load 0x0000_0300 (same index 0x10, different tag).
  - Response: 4 writeback beats to 0x100..0x10C with the stored data, including 0xDEAD_BEEF at 0x108.
  - Then 4 refill beats at 0x300..0x30C; total stall 9 cycles.
- Slow memory: ack every third cycle on a clean miss.
  - Response: mem_req_o stays high continuously, stall lasts 12+1 cycles, and the address advances only on ack.
- Reset mid-refill: assert rst_i after 2 refill acks.
  - Response: next cycle mem_req_o=0 and stall_o=0 with req_i low. Re-reading the address misses again.
- Store miss: store 0x5 to 0x0000_0400 into a clean line.
  - Response: refill, then the word is written and dirty is set; a later load returns 0x5.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared types and field-width helpers for the direct-mapped write-back data cache.
package data_cache_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    function automatic int word_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words);
        return ADDR_W - 2 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag, valid, dirty and data storage: combinational read of one line/word, one word write port.
module data_cache_array
    import data_cache_pkg::*;
#(
    parameter  int LINES   = 32,
    parameter  int WORDS   = 4,
    localparam int WORD_W  = word_w(WORDS),
    localparam int INDEX_W = index_w(LINES),
    localparam int TAG_W   = tag_w(LINES, WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] index,
    input  logic [WORD_W-1:0]  word,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               set_dirty,
    input  logic               fill,
    input  logic [TAG_W-1:0]   fill_tag
);

    logic [DATA_W-1:0] data_q [LINES*WORDS];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [INDEX_W+WORD_W-1:0] slot;

    assign slot     = {index, word};
    assign rd_data  = data_q[slot];
    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

    // NOTE: data and tag arrays carry no reset; the valid bit alone decides whether their contents mean anything.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            data_q[slot] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[index] <= fill_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
            if (set_dirty) begin
                dirty_q[index] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: FSM, beat counter, hit logic and memory port.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int WORD_W  = word_w(WORDS);
    localparam int INDEX_W = index_w(LINES);
    localparam int TAG_W   = tag_w(LINES, WORDS);

    logic [WORD_W-1:0]  addr_word;
    logic [INDEX_W-1:0] addr_index;
    logic [TAG_W-1:0]   addr_tag;
    logic               unused_addr_bits;

    assign addr_word        = addr_i[WORD_W+1:2];
    assign addr_index       = addr_i[WORD_W+INDEX_W+1:WORD_W+2];
    assign addr_tag         = addr_i[31:WORD_W+INDEX_W+2];
    assign unused_addr_bits = ^addr_i[1:0];

    state_e            state_q, state_d;
    logic [WORD_W-1:0] beat_q, beat_d;

    logic               line_valid, line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [31:0]        line_data;
    logic [WORD_W-1:0]  arr_word;
    logic               arr_wr_en, set_dirty, fill;
    logic [31:0]        arr_wr_data;
    logic               hit, last_beat;

    data_cache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .index     (addr_index),
        .word      (arr_word),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (arr_wr_en),
        .wr_data   (arr_wr_data),
        .set_dirty (set_dirty),
        .fill      (fill),
        .fill_tag  (addr_tag)
    );

    assign hit       = req_i & line_valid & (line_tag == addr_tag);
    assign last_beat = &beat_q;

    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        arr_word    = addr_word;
        arr_wr_en   = 1'b0;
        arr_wr_data = wdata_i;
        set_dirty   = 1'b0;
        fill        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i && hit && we_i) begin
                    arr_wr_en = 1'b1;
                    set_dirty = 1'b1;
                end else if (req_i && !hit) begin
                    beat_d  = '0;
                    state_d = (line_valid && line_dirty) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                arr_word = beat_q;
                if (mem_ack_i) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = REFILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                arr_word    = beat_q;
                arr_wr_data = mem_rdata_i;
                if (mem_ack_i) begin
                    arr_wr_en = 1'b1;
                    if (last_beat) begin
                        fill    = 1'b1;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Beat address/data follow state and beat counter, so they move only on an acked edge or state entry.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            WRITEBACK: begin
                mem_addr_o  = {line_tag, addr_index, beat_q, 2'b00};
                mem_wdata_o = line_data;
            end
            REFILL:  mem_addr_o = {addr_tag, addr_index, beat_q, 2'b00};
            default: mem_addr_o = '0;
        endcase
    end

    assign mem_req_o = (state_q != IDLE);
    assign mem_we_o  = (state_q == WRITEBACK);
    assign stall_o   = (state_q != IDLE) | (req_i & ~hit);
    assign rdata_o   = (state_q == IDLE && req_i && !we_i && hit) ? line_data : '0;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed accesses, a memory responder and a CPU-view model.
module tb_data_cache;

    localparam int LINES = 32;
    localparam int WORDS = 4;

    logic        clk_i = 1'b0;
    logic        rst_i, req_i, we_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    data_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we;
        logic [31:0] addr;
    } beat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    beat_t       beat_log [$];
    logic [31:0] mem_q    [logic [31:0]];
    logic [31:0] cpu_view [logic [31:0]];
    bit          m_valid  [LINES];
    bit          m_dirty  [LINES];
    int unsigned m_tag    [LINES];
    int          wait_states = 0;
    bit          stray_ack   = 1'b0;
    int          req_cycles  = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11;
            32'h104: return 32'h22;
            32'h108: return 32'h33;
            32'h10C: return 32'h44;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_q.exists(a) ? mem_q[a] : init_word(a);
    endfunction

    function automatic logic [31:0] cpu_rd(input logic [31:0] a);
        return cpu_view.exists(a) ? cpu_view[a] : init_word(a);
    endfunction

    // Expected stall from the line table: hit, clean miss or dirty miss, scaled by memory wait states.
    function automatic int model_stall(input logic [31:0] a);
        int unsigned idx, tg;
        int beats;
        idx = (a / (4 * WORDS)) % LINES;
        tg  = a / (4 * WORDS * LINES);
        if (m_valid[idx] && m_tag[idx] == tg) return 0;
        beats = (m_valid[idx] && m_dirty[idx]) ? 2 * WORDS : WORDS;
        return beats * (wait_states + 1) + 1;
    endfunction

    task automatic model_commit(input bit we, input logic [31:0] a, input logic [31:0] d);
        int unsigned idx, tg;
        idx = (a / (4 * WORDS)) % LINES;
        tg  = a / (4 * WORDS * LINES);
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_dirty[idx] = 1'b1;
            cpu_view[a]  = d;
        end
    endtask

    task automatic model_reset();
        cpu_view = mem_q;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Memory responder: acks every (wait_states+1)th cycle of mem_req_o; stray_ack pulses ack while idle.
    initial begin
        int wcnt;
        wcnt        = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_rdata_i = 32'hBAD0_BAD0;
            if (rst_i || !mem_req_o) begin
                wcnt      = 0;
                mem_ack_i = stray_ack;
            end else if (wcnt == wait_states) begin
                wcnt      = 0;
                mem_ack_i = 1'b1;
                if (!mem_we_o) mem_rdata_i = mem_rd(mem_addr_o);
            end else begin
                wcnt++;
                mem_ack_i = 1'b0;
            end
        end
    end

    // Per-cycle compare against the CPU-visible memory image.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (req_i && !we_i && !stall_o) check("load_data", rdata_o, cpu_rd(addr_i));
            if (!req_i && !mem_req_o) begin
                check("idle_stall", stall_o, 0);
                check("idle_rdata", rdata_o, 0);
            end
            if (mem_req_o && prev_req && !prev_ack) check("addr_hold", mem_addr_o, prev_addr);
            if (mem_req_o) req_cycles++;
            if (mem_req_o && mem_ack_i) begin
                beat_log.push_back('{mem_we_o, mem_addr_o});
                if (mem_we_o) begin
                    check("wb_data", mem_wdata_o, cpu_rd(mem_addr_o));
                    mem_q[mem_addr_o] = mem_wdata_o;
                end
            end
        end
        prev_req  = mem_req_o;
        prev_ack  = mem_ack_i;
        prev_addr = mem_addr_o;
    end

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input int exp_stall, output logic [31:0] rd);
        int m_st, stalls;
        m_st = model_stall(a);
        beat_log.delete();
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        wdata_i = d;
        stalls  = 0;
        @(negedge clk_i);
        while (stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
        end
        rd = rdata_o;
        check("stall_cycles", stalls, exp_stall);
        check("stall_model", stalls, m_st);
        @(posedge clk_i);
        #1;
        model_commit(we, a, d);
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic check_burst(input int first, input bit we, input logic [31:0] base);
        for (int i = 0; i < WORDS; i++) begin
            check("beat_we", beat_log[first+i].we, we);
            check("beat_addr", beat_log[first+i].addr, base + 32'(4 * i));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int cyc;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_rdata", rdata_o, 0);
        @(posedge clk_i);
        #1;

        // Cold load, then a hit on the same line
        access(1'b0, 32'h100, 32'h0, 5, rd);
        check("cold_rdata", rd, 32'h11);
        check("cold_beats", beat_log.size(), 4);
        check_burst(0, 1'b0, 32'h100);
        access(1'b0, 32'h104, 32'h0, 0, rd);
        check("hit_rdata", rd, 32'h22);

        // Store hit: no traffic, data visible to a later load
        access(1'b1, 32'h108, 32'hDEAD_BEEF, 0, rd);
        check("store_hit_traffic", beat_log.size(), 0);
        access(1'b0, 32'h108, 32'h0, 0, rd);
        check("store_hit_rdata", rd, 32'hDEAD_BEEF);

        // Dirty eviction from index 0x10
        access(1'b0, 32'h300, 32'h0, 9, rd);
        check("evict_beats", beat_log.size(), 8);
        check_burst(0, 1'b1, 32'h100);
        check_burst(4, 1'b0, 32'h300);
        check("evict_mem_108", mem_rd(32'h108), 32'hDEAD_BEEF);
        check("evict_mem_100", mem_rd(32'h100), 32'h11);
        check("evict_rdata", rd, 32'h5A5A_0300);

        // Slow memory: ack every third cycle on a clean miss
        wait_states = 2;
        req_cycles  = 0;
        access(1'b0, 32'h704, 32'h0, 13, rd);
        check("slow_req_cycles", req_cycles, 12);
        check_burst(0, 1'b0, 32'h700);
        check("slow_rdata", rd, 32'h5A5A_0704);
        wait_states = 0;

        // Reset after two refill acks
        beat_log.delete();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h600;
        cyc = 0;
        while (beat_log.size() < 2 && cyc < 50) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check("mid_rst_acks", beat_log.size(), 2);
        rst_i = 1'b1;
        req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        check("mid_rst_mem_req", mem_req_o, 0);
        check("mid_rst_stall", stall_o, 0);

        // Stray acks while idle must be ignored; the address misses again
        @(posedge clk_i);
        #1 stray_ack = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 stray_ack = 1'b0;
        access(1'b0, 32'h600, 32'h0, 5, rd);
        check_burst(0, 1'b0, 32'h600);
        check("rerd_rdata", rd, 32'h5A5A_0600);

        // Store miss into a clean line, then evict it to see the dirty word written back
        access(1'b1, 32'h400, 32'h5, 5, rd);
        check_burst(0, 1'b0, 32'h400);
        access(1'b0, 32'h400, 32'h0, 0, rd);
        check("store_miss_rdata", rd, 32'h5);
        access(1'b0, 32'h600, 32'h0, 9, rd);
        check_burst(0, 1'b1, 32'h400);
        check("store_miss_wb", mem_rd(32'h400), 32'h5);
        check("reload_rdata", rd, 32'h5A5A_0600);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
